// File: rtl/vector_issue_ctrl.sv
// vector_issue_ctrl: round-robin VRF issue arbiter with RAW/WAW hazard tracking and a one-entry issue stage.
// Define VECTOR_ISSUE_WB_BYPASS_EN to let a same-cycle writeback clear the hazard it resolves.
module vector_issue_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int VREG_W = 6,
    parameter int MAX_OUT = 4,
    parameter int CNT_W = 3,
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int NV = 1 << VREG_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*VREG_W-1:0] req_vs1,
    input  logic [NUM_REQ*VREG_W-1:0] req_vs2,
    input  logic [NUM_REQ*VREG_W-1:0] req_vd,
    input  logic [NUM_REQ-1:0]        req_wen,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [SW-1:0]             iss_src,
    output logic [VREG_W-1:0]         iss_vs1,
    output logic [VREG_W-1:0]         iss_vs2,
    output logic [VREG_W-1:0]         iss_vd,
    output logic                      iss_wen,
    input  logic                      accomplished,
    input  logic                      wb_valid,
    input  logic [VREG_W-1:0]         wb_vd,
    output logic [CNT_W-1:0]          outstanding,
    output logic [NV-1:0]             pending,
    output logic                      busy,
    output logic                      flush_done,
    output logic                      err
);
    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;
    state_t state, state_n;
    logic held, any_gnt, can_issue, acc_ok, sel_wen;
    logic [SW-1:0] ptr, gnt_id;
    logic [NUM_REQ-1:0] elig;
    logic [NV-1:0] wb_clr, pend_eff, gnt_set;
    logic [VREG_W-1:0] sel_vs1, sel_vs2, sel_vd;
    int idx;

    assign wb_clr = wb_valid ? NV'(1) << wb_vd : '0;
`ifdef VECTOR_ISSUE_WB_BYPASS_EN
    assign pend_eff = pending & ~wb_clr;
`else
    assign pend_eff = pending;
`endif
    assign can_issue = !RST && !flush && state != FLUSH && outstanding < CNT_W'(MAX_OUT) && (!held || iss_ready);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign elig[i] = req_valid[i] && can_issue
            && !pend_eff[req_vs1[i*VREG_W +: VREG_W]] && !pend_eff[req_vs2[i*VREG_W +: VREG_W]]
            && !(req_wen[i] && pend_eff[req_vd[i*VREG_W +: VREG_W]]);
    end

    // Scan from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        req_ready = '0;
        gnt_id = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (elig[idx[SW-1:0]]) begin
                req_ready = '0;
                req_ready[idx[SW-1:0]] = 1'b1;
                gnt_id = idx[SW-1:0];
            end
        end
    end

    assign any_gnt = |req_ready;
    assign sel_vs1 = req_vs1[int'(gnt_id)*VREG_W +: VREG_W];
    assign sel_vs2 = req_vs2[int'(gnt_id)*VREG_W +: VREG_W];
    assign sel_vd = req_vd[int'(gnt_id)*VREG_W +: VREG_W];
    assign sel_wen = req_wen[gnt_id];
    assign gnt_set = (any_gnt && sel_wen) ? NV'(1) << sel_vd : '0;
    assign acc_ok = accomplished && outstanding != '0;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = flush ? FLUSH : any_gnt ? HOLD : IDLE;
            HOLD: state_n = flush ? FLUSH : (iss_ready && !any_gnt) ? IDLE : HOLD;
            FLUSH: state_n = (!held && outstanding == '0) ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        iss_valid = held;
        busy = state != IDLE || outstanding != '0;
        flush_done = state == FLUSH && !held && outstanding == '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            held <= 1'b0;
            ptr <= '0;
            outstanding <= '0;
            pending <= '0;
            err <= 1'b0;
            iss_src <= '0;
            iss_vs1 <= '0;
            iss_vs2 <= '0;
            iss_vd <= '0;
            iss_wen <= 1'b0;
        end else begin
            held <= any_gnt || (held && !iss_ready);
            ptr <= any_gnt ? ((int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + SW'(1)) : ptr;
            outstanding <= outstanding + CNT_W'(any_gnt) - CNT_W'(acc_ok);
            pending <= (pending & ~wb_clr) | gnt_set;
            err <= err || (accomplished && !acc_ok) || (wb_valid && !pending[wb_vd]);
            if (any_gnt) begin
                iss_src <= gnt_id;
                iss_vs1 <= sel_vs1;
                iss_vs2 <= sel_vs2;
                iss_vd <= sel_vd;
                iss_wen <= sel_wen;
            end
        end
    end
endmodule

// File: tb/tb_vector_issue_ctrl.sv
// tb_vector_issue_ctrl: table-driven round-robin vectors plus directed hazard, stall, limit, flush and reset sequences.
module tb_vector_issue_ctrl;
    logic CLK = 1'b0, RST = 1'b1;
    logic [1:0] req_valid = '0, req_wen = '0, req_ready;
    logic [11:0] req_vs1 = '0, req_vs2 = '0, req_vd = '0;
    logic flush = 1'b0, iss_valid, iss_ready = 1'b1, iss_src, iss_wen;
    logic [5:0] iss_vs1, iss_vs2, iss_vd, wb_vd = '0;
    logic accomplished = 1'b0, wb_valid = 1'b0;
    logic [2:0] outstanding;
    logic [63:0] pending;
    logic busy, flush_done, err;
    int total = 0, passed = 0;

    vector_issue_ctrl dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_vd(req_vd), .req_wen(req_wen), .req_ready(req_ready), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src(iss_src), .iss_vs1(iss_vs1),
        .iss_vs2(iss_vs2), .iss_vd(iss_vd), .iss_wen(iss_wen), .accomplished(accomplished),
        .wb_valid(wb_valid), .wb_vd(wb_vd), .outstanding(outstanding), .pending(pending),
        .busy(busy), .flush_done(flush_done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] rv, wen;
        logic acc, wbv;
        logic [5:0] wbvd;
        logic [1:0] rdy;
        logic iv, src;
        logic [5:0] vd;
        logic [2:0] out;
        logic [63:0] pend;
        logic bsy;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b, input logic [5:0] d, input logic w);
        req_vs1[i*6 +: 6] = a;
        req_vs2[i*6 +: 6] = b;
        req_vd[i*6 +: 6] = d;
        req_wen[i] = w;
    endtask

    task automatic drive(input logic [1:0] rv, input logic rdy, input logic acc, input logic fl,
                         input logic wbv, input logic [5:0] wbvd);
        req_valid = rv;
        iss_ready = rdy;
        accomplished = acc;
        flush = fl;
        wb_valid = wbv;
        wb_vd = wbvd;
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 2'b11, 1'b0, 1'b0, 6'd0, 2'b01, 1'b0, 1'b0, 6'd0, 3'd0, 64'h0,  1'b0};
        tbl[1]  = '{2'b11, 2'b11, 1'b0, 1'b0, 6'd0, 2'b10, 1'b1, 1'b0, 6'd3, 3'd1, 64'h8,  1'b1};
        tbl[2]  = '{2'b11, 2'b11, 1'b0, 1'b0, 6'd0, 2'b00, 1'b1, 1'b1, 6'd6, 3'd2, 64'h48, 1'b1};
        tbl[3]  = '{2'b00, 2'b00, 1'b1, 1'b1, 6'd3, 2'b00, 1'b0, 1'b1, 6'd6, 3'd2, 64'h48, 1'b1};
        tbl[4]  = '{2'b00, 2'b00, 1'b1, 1'b1, 6'd6, 2'b00, 1'b0, 1'b1, 6'd6, 3'd1, 64'h40, 1'b1};
        tbl[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 6'd0, 2'b01, 1'b0, 1'b1, 6'd6, 3'd0, 64'h0,  1'b0};
        tbl[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 6'd0, 2'b10, 1'b1, 1'b0, 6'd3, 3'd1, 64'h0,  1'b1};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 6'd0, 2'b01, 1'b1, 1'b1, 6'd6, 3'd2, 64'h0,  1'b1};
        tbl[8]  = '{2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 1'b1, 1'b0, 6'd3, 3'd3, 64'h0,  1'b1};
        tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 1'b0, 1'b0, 6'd3, 3'd2, 64'h0,  1'b1};
        tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 1'b0, 1'b0, 6'd3, 3'd1, 64'h0,  1'b1};
        tbl[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 2'b00, 1'b0, 1'b0, 6'd3, 3'd0, 64'h0,  1'b0};

        repeat (2) cyc;
        RST = 1'b0;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rst iss_valid", iss_valid, 0);
        chk("rst outstanding", outstanding, 0);
        chk("rst pending", pending, 0);
        chk("rst err", err, 0);
        chk("rst busy", busy, 0);
        chk("rst flush_done", flush_done, 0);
        chk("rst req_ready", req_ready, 0);

        // round robin over independent registers
        set_req(0, 6'd1, 6'd2, 6'd3, 1'b1);
        set_req(1, 6'd4, 6'd5, 6'd6, 1'b1);
        for (int i = 0; i < 12; i++) begin
            req_wen = tbl[i].wen;
            drive(tbl[i].rv, 1'b1, tbl[i].acc, 1'b0, tbl[i].wbv, tbl[i].wbvd);
            chk($sformatf("t%0d req_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("t%0d iss_valid", i), iss_valid, tbl[i].iv);
            chk($sformatf("t%0d iss_src", i), iss_src, tbl[i].src);
            chk($sformatf("t%0d iss_vd", i), iss_vd, tbl[i].vd);
            chk($sformatf("t%0d outstanding", i), outstanding, tbl[i].out);
            chk($sformatf("t%0d pending", i), pending, tbl[i].pend);
            chk($sformatf("t%0d busy", i), busy, tbl[i].bsy);
            cyc;
        end

        // RAW hazard resolved by writeback (pointer now at 1)
        set_req(0, 6'd0, 6'd0, 6'd10, 1'b1);
        set_req(1, 6'd10, 6'd11, 6'd12, 1'b1);
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("raw grant0", req_ready, 2'b01);
        cyc;
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("raw blocked", req_ready, 2'b00);
        chk("raw pending10", pending, 64'h400);
        cyc;
        drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 6'd10);
`ifdef VECTOR_ISSUE_WB_BYPASS_EN
        chk("raw wb cycle", req_ready, 2'b10);
`else
        chk("raw wb cycle", req_ready, 2'b00);
`endif
        cyc;
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
`ifdef VECTOR_ISSUE_WB_BYPASS_EN
        chk("raw after wb", req_ready, 2'b00);
`else
        chk("raw after wb", req_ready, 2'b10);
`endif
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("raw pending12", pending, 64'h1000);
        chk("raw outstanding", outstanding, 1);
        chk("raw iss_vd", iss_vd, 12);
        cyc;
        drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 6'd12);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("raw drained out", outstanding, 0);
        chk("raw drained pend", pending, 0);
        chk("raw err", err, 0);
        cyc;

        // stall with iss_ready low (pointer at 0)
        set_req(0, 6'd1, 6'd2, 6'd3, 1'b0);
        set_req(1, 6'd4, 6'd5, 6'd6, 1'b0);
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("stall grant0", req_ready, 2'b01);
        cyc;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            chk($sformatf("stall%0d req_ready", i), req_ready, 2'b00);
            chk($sformatf("stall%0d iss_valid", i), iss_valid, 1);
            chk($sformatf("stall%0d iss_vd", i), iss_vd, 3);
            chk($sformatf("stall%0d iss_src", i), iss_src, 0);
            cyc;
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("stall b2b grant", req_ready, 2'b10);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("stall b2b valid", iss_valid, 1);
        chk("stall b2b src", iss_src, 1);
        chk("stall b2b vd", iss_vd, 6);
        chk("stall b2b out", outstanding, 2);
        cyc;
        repeat (2) begin
            drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
            cyc;
        end

        // outstanding limit (pointer at 0)
        repeat (4) begin
            drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
            cyc;
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("max out", outstanding, 4);
        chk("max no grant", req_ready, 2'b00);
        cyc;
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("max acc no grant", req_ready, 2'b00);
        cyc;
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("max out3", outstanding, 3);
        chk("max regrant", req_ready, 2'b01);
        cyc;
        drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        cyc;
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("max grant+acc rdy", req_ready, 2'b10);
        chk("max grant+acc pre", outstanding, 3);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("max grant+acc out", outstanding, 3);
        chk("max grant+acc src", iss_src, 1);
        cyc;
        repeat (3) begin
            drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
            cyc;
        end
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("max drained", outstanding, 0);
        chk("max idle busy", busy, 0);
        cyc;

        // flush with two in flight and a held op
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        cyc;
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        cyc;
        drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        chk("fl held", iss_valid, 1);
        chk("fl out2", outstanding, 2);
        cyc;
        drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("fl no grant", req_ready, 2'b00);
        chk("fl still held", iss_valid, 1);
        chk("fl busy", busy, 1);
        chk("fl done early", flush_done, 0);
        cyc;
        drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("fl no grant2", req_ready, 2'b00);
        cyc;
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("fl issued", iss_valid, 0);
        chk("fl no grant3", req_ready, 2'b00);
        chk("fl done early2", flush_done, 0);
        cyc;
        drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("fl out1", outstanding, 1);
        chk("fl done early3", flush_done, 0);
        chk("fl no grant4", req_ready, 2'b00);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("fl done pulse", flush_done, 1);
        chk("fl out0", outstanding, 0);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("fl done cleared", flush_done, 0);
        chk("fl idle", busy, 0);
        cyc;

        // reset mid-HOLD, then accomplished at zero
        set_req(0, 6'd1, 6'd2, 6'd3, 1'b1);
        drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 6'd20);
        chk("rh grant", req_ready, 2'b01);
        cyc;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rh err wb", err, 1);
        chk("rh held", iss_valid, 1);
        chk("rh pending", pending, 64'h8);
        cyc;
        RST = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        cyc;
        RST = 1'b0;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rh iss_valid", iss_valid, 0);
        chk("rh pending0", pending, 0);
        chk("rh out0", outstanding, 0);
        chk("rh err0", err, 0);
        chk("rh busy0", busy, 0);
        cyc;
        drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        cyc;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("acc0 err", err, 1);
        chk("acc0 out", outstanding, 0);
        cyc;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
